// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: RV32I requests to word-aligned memory
// transactions with byte lanes, load formatting, stall and timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] D_out,
  output logic        busywait,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [TO_W:0] TO_LIM =
    (TO_W+1)'(TIMEOUT_CYCLES);

  state_t state, state_nx;

  logic [29:0]     addr_q;
  logic [1:0]      k_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [3:0]      be_q;
  logic [31:0]     wd_q;
  logic [TO_W-1:0] cnt;
  logic [TO_W:0]   cnt_inc;

  logic [1:0]  k;
  logic        any, mis, req;
  logic        acc, timeout;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_fmt;

  assign k       = alu_result[1:0];
  assign any     = mem_read | mem_write;
  assign req     = any & ~mis;
  assign acc     = (state == ACCESS);
  assign cnt_inc = {1'b0, cnt} + 1'b1;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      funct3[1:0] == 2'b01: mis = k[0];
      funct3[1:0] == 2'b10: mis = |k;
      default:              mis = 1'b0;
    endcase
  end

  assign misaligned = (state == IDLE) & any & mis;

  // Loads read the whole word; only stores narrow the lanes.
  always_comb begin
    be_nx = 4'b1111;
    wd_nx = 32'h0;
    if (mem_write) begin
      unique case (1'b1)
        funct3 == 3'b000: begin
          be_nx = 4'b0001 << k;
          wd_nx = {4{rs2_data[7:0]}};
        end
        funct3 == 3'b001: begin
          be_nx = 4'b0011 << k;
          wd_nx = {2{rs2_data[15:0]}};
        end
        default: wd_nx = rs2_data;
      endcase
    end
  end

  assign byte_v = dmem_rdata[8*k_q +: 8];
  assign half_v = k_q[1] ? dmem_rdata[31:16]
                         : dmem_rdata[15:0];

  always_comb begin
    ld_fmt = dmem_rdata;
    case (f3_q)
      3'b000:  ld_fmt = {{24{byte_v[7]}}, byte_v};
      3'b100:  ld_fmt = {24'h0, byte_v};
      3'b001:  ld_fmt = {{16{half_v[15]}}, half_v};
      3'b101:  ld_fmt = {16'h0, half_v};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    busywait = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      IDLE: begin
        busywait = req & ~reset;
        if (req) state_nx = ACCESS;
      end
      ACCESS: begin
        busywait = 1'b1;
        if (dmem_ack) begin
          state_nx = DONE;
        end else if (TIMEOUT_CYCLES != 0 &&
                     cnt_inc == TO_LIM) begin
          timeout  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      k_q       <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      be_q      <= '0;
      wd_q      <= '0;
      cnt       <= '0;
      D_out     <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nx;
      bus_error <= timeout;
      if (state == IDLE && req) begin
        addr_q <= alu_result[31:2];
        k_q    <= k;
        we_q   <= mem_write;
        f3_q   <= funct3;
        be_q   <= be_nx;
        wd_q   <= wd_nx;
        cnt    <= '0;
      end else if (acc && !dmem_ack) begin
        cnt <= cnt_inc[TO_W-1:0];
      end
      if (acc && !we_q) begin
        if (dmem_ack)     D_out <= ld_fmt;
        else if (timeout) D_out <= '0;
      end
    end
  end

  assign dmem_req   = acc;
  assign dmem_we    = acc & we_q;
  assign dmem_addr  = acc ? {addr_q, 2'b00} : 32'h0;
  assign dmem_be    = acc ? be_q : 4'h0;
  assign dmem_wdata = acc ? wd_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: lanes, formatting,
// stalls, misalignment, timeout and async reset.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] D_out;
  logic        busywait;
  logic        misaligned;
  logic        bus_error;

  int n_cmp;
  int n_err;

  mem_access_unit #(
    .TIMEOUT_CYCLES(4),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .funct3(funct3),
    .alu_result(alu_result),
    .rs2_data(rs2_data),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .D_out(D_out),
    .busywait(busywait),
    .misaligned(misaligned),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE through DONE; ack arrives on
  // ACCESS cycle number dly (0-based), dly>=20 means never.
  task automatic txn(input string tag,
                     input logic rd, input logic wr,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rdat,
                     input int dly,
                     input logic [31:0] e_addr,
                     input logic [3:0] e_be,
                     input logic [31:0] e_wd,
                     input logic [31:0] e_dout,
                     input int e_bw,
                     input logic e_berr);
    int  bw;
    bit  done;
    bw   = 0;
    done = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = a;
    rs2_data   = wd;
    dmem_rdata = rdat;
    for (int c = 0; c < 20 && !done; c++) begin
      dmem_ack = (c == dly + 1);
      @(negedge clk);
      if (busywait) bw++;
      if (dmem_req) begin
        chk({tag, ".addr"}, dmem_addr, e_addr);
        chk({tag, ".be"}, 32'(dmem_be), 32'(e_be));
        chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
        chk({tag, ".mis"}, 32'(misaligned), 32'h0);
        if (wr) chk({tag, ".wdata"}, dmem_wdata, e_wd);
      end
      if (c > 0 && !busywait) begin
        chk({tag, ".dout"}, D_out, e_dout);
        chk({tag, ".req_done"}, 32'(dmem_req), 32'h0);
        chk({tag, ".berr"}, 32'(bus_error), 32'(e_berr));
        done      = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      tick();
    end
    dmem_ack = 1'b0;
    chk({tag, ".finished"}, 32'(done), 32'h1);
    chk({tag, ".bw_cycles"}, 32'(bw), 32'(e_bw));
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    funct3     = 3'b010;
    alu_result = 32'h100;
    rs2_data   = 32'h0;
    dmem_rdata = 32'h0;
    dmem_ack   = 1'b0;

    @(negedge clk);
    chk("rst.req", 32'(dmem_req), 32'h0);
    chk("rst.busy", 32'(busywait), 32'h0);
    chk("rst.dout", D_out, 32'h0);
    chk("rst.berr", 32'(bus_error), 32'h0);
    chk("rst.be", 32'(dmem_be), 32'h0);
    chk("rst.addr", dmem_addr, 32'h0);
    mem_read = 1'b0;
    tick();
    reset = 1'b0;

    txn("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0,
        32'h100, 4'hF, 0, 32'hDEADBEEF, 2, 0);
    txn("lb", 1, 0, 3'b000, 32'h203, 0, 32'h80FF1234, 0,
        32'h200, 4'hF, 0, 32'hFFFFFF80, 2, 0);
    txn("lbu", 1, 0, 3'b100, 32'h203, 0, 32'h80FF1234, 0,
        32'h200, 4'hF, 0, 32'h00000080, 2, 0);
    txn("lh", 1, 0, 3'b001, 32'h202, 0, 32'h80FF1234, 0,
        32'h200, 4'hF, 0, 32'hFFFF80FF, 2, 0);
    txn("lhu", 1, 0, 3'b101, 32'h200, 0, 32'h80FF1234, 0,
        32'h200, 4'hF, 0, 32'h00001234, 2, 0);
    txn("sb", 0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 3,
        32'h100, 4'b0010, 32'hABABABAB, 32'h00001234, 5, 0);
    txn("sh", 0, 1, 3'b001, 32'h202, 32'h12345678, 0, 1,
        32'h200, 4'b1100, 32'h56785678, 32'h00001234, 3, 0);
    txn("rw", 1, 1, 3'b010, 32'h304, 32'hCAFEF00D, 0, 0,
        32'h304, 4'hF, 32'hCAFEF00D, 32'h00001234, 2, 0);

    mem_read   = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h102;
    @(negedge clk);
    chk("mis_lw.flag", 32'(misaligned), 32'h1);
    chk("mis_lw.busy", 32'(busywait), 32'h0);
    tick();
    @(negedge clk);
    chk("mis_lw.req", 32'(dmem_req), 32'h0);
    chk("mis_lw.dout", D_out, 32'h00001234);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    funct3     = 3'b001;
    alu_result = 32'h101;
    rs2_data   = 32'h5555;
    #1;
    chk("mis_sh.flag", 32'(misaligned), 32'h1);
    chk("mis_sh.busy", 32'(busywait), 32'h0);
    tick();
    @(negedge clk);
    chk("mis_sh.req", 32'(dmem_req), 32'h0);
    mem_write = 1'b0;
    tick();

    txn("tmo", 1, 0, 3'b010, 32'h300, 0, 32'h11111111, 99,
        32'h300, 4'hF, 0, 32'h0, 5, 1);
    @(negedge clk);
    chk("tmo.pulse_end", 32'(bus_error), 32'h0);
    chk("tmo.idle_req", 32'(dmem_req), 32'h0);
    tick();

    txn("pre", 1, 0, 3'b100, 32'h401, 0, 32'h0000A500, 0,
        32'h400, 4'hF, 0, 32'h000000A5, 2, 0);

    mem_read   = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h400;
    @(negedge clk);
    chk("ar.idle_busy", 32'(busywait), 32'h1);
    tick();
    @(negedge clk);
    chk("ar.acc_req", 32'(dmem_req), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar.req", 32'(dmem_req), 32'h0);
    chk("ar.busy", 32'(busywait), 32'h0);
    chk("ar.dout", D_out, 32'h0);
    mem_read = 1'b0;
    tick();
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h77777777;
    @(negedge clk);
    chk("ar.late_req", 32'(dmem_req), 32'h0);
    chk("ar.late_busy", 32'(busywait), 32'h0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("ar.ack_ignored", D_out, 32'h0);
    tick();

    txn("post", 1, 0, 3'b010, 32'h404, 0, 32'h0BADC0DE, 2,
        32'h404, 4'hF, 0, 32'h0BADC0DE, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine. It sits between the EX/MEM pipeline register and the data memory port, and feeds D_out and busywait to the MEM/WB pipeline register.
- Converts RV32I load/store requests into word-aligned memory transactions with byte enables.
- Stalls the pipeline through busywait until the memory acknowledges.
- Formats load data with sign or zero extension.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in ACCESS waiting for dmem_ack before the access is aborted with bus_error. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  current MEM instruction is a load
- mem_write  in  1  current MEM instruction is a store
- funct3  in  3  RV32I size/sign code
- alu_result  in  32  effective byte address
- rs2_data  in  32  store data
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: {addr[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read word, valid with ack
- dmem_ack  in  1  one-cycle completion strobe
- D_out  out  32  formatted load result (registered)
- busywait  out  1  stall request to all pipeline registers
- misaligned  out  1  combinational fault flag for the current request
- bus_error  out  1  one-cycle pulse when a timeout abort occurs

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, D_out, bus_error and the timeout counter all go to 0.
  - busywait is 0 while reset is high.
- Request: req = (mem_read | mem_write) & ~misaligned. If mem_read and mem_write are both high, the access is a write.
- Misaligned:
  - Halfword (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word (funct3[1:0]=10) with addr[1:0]!=0 is misaligned.
  - A misaligned request issues no memory access, keeps busywait=0, and leaves D_out unchanged.
  - misaligned is evaluated in IDLE only; it is 0 in ACCESS and DONE.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - busywait = req, combinationally in the same cycle.
    - On req, latch addr, write flag, funct3, dmem_be and dmem_wdata into internal registers, clear the timeout counter, and go to ACCESS.
  - ACCESS:
    - dmem_req=1; dmem_we, dmem_addr, dmem_be and dmem_wdata are driven from the latched registers and are stable for the whole state.
    - busywait=1.
    - On dmem_ack: a load writes the formatted dmem_rdata into D_out; a store leaves D_out unchanged. Go to DONE.
    - Otherwise the counter increments. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, pulse bus_error next cycle, set D_out=0 for a load, and go to DONE.
    - If ack and timeout occur in the same cycle, ack wins.
  - DONE:
    - busywait=0 and dmem_req=0.
    - Go to IDLE unconditionally. mem_read/mem_write are ignored here because they still belong to the completing instruction.
- Minimum access latency: busywait reads 1,1,0 (IDLE, ACCESS with immediate ack, DONE), i.e. two stall cycles.
- dmem_ack received outside ACCESS is ignored.
- Store lanes, with k = addr[1:0]:
  - SB (000): be = 4'b0001<<k, wdata = {4{rs2[7:0]}}.
  - SH (001): be = 4'b0011<<k, wdata = {2{rs2[15:0]}}.
  - SW (010): be = 4'b1111, wdata = rs2.
  - Other funct3 values are treated as SW.
- Load formatting, with byte = rdata[8k+7:8k] and half = rdata[16*k[1]+15:16*k[1]]:
  - LB (000): sign-extend byte. LBU (100): zero-extend byte.
  - LH (001): sign-extend half. LHU (101): zero-extend half.
  - LW (010) and all other codes: full word.
- Loads drive dmem_be=4'b1111.

Test Plan:
- LW at 0x100, ack on the 1st ACCESS cycle, rdata=0xDEADBEEF -> busywait 1,1,0; dmem_addr=0x100, be=1111, we=0; D_out=0xDEADBEEF in the DONE cycle.
- LB at 0x203 with rdata=0x80FF_1234 -> dmem_addr=0x200, D_out=0xFFFFFF80. Repeat as LBU -> D_out=0x00000080. LH at 0x202 -> D_out=0xFFFF80FF.
- SB at 0x101 with rs2=0x000000AB, ack delayed 3 cycles -> be=0010, wdata=0xABABABAB, dmem_req and bus signals stable across the 4 ACCESS cycles; busywait high for 5 cycles total; D_out unchanged.
- LW at 0x102 -> misaligned=1, busywait=0, dmem_req never asserts. SH at 0x101 -> same response.
- TIMEOUT_CYCLES=4, LW with no ack -> 5 busywait-high cycles (IDLE + 4 ACCESS), then a bus_error pulse and D_out=0 in DONE, then return to IDLE.
- Assert reset during ACCESS -> dmem_req=0 and busywait=0 immediately (asynchronous). After release, the FSM is in IDLE and a later ack is ignored.
